// File: rtl/if_pkg.sv
// Shared constants and prefetch-queue entry layout for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and fall-through head (read data is the
// entry at the read pointer, no read latency).
module if_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_wr     = i_wr_en && !full;
  assign do_rd     = i_rd_en && !empty;
  assign o_rd_data = mem[rd_ptr];
  assign o_count   = count;

  // Pointers wrap naturally since DEPTH is a power of two; flush discards everything.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_wr && !do_rd) begin
        count <= count + CNT_W'(1);
      end else if (!do_wr && do_rd) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the PC, keeps several fetches in flight against a
// variable-latency memory and buffers in-order responses in a prefetch queue for decode.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_redirect,
  input  logic [XLEN-1:0]           i_redirect_pc,
  output logic                      o_imem_req_valid,
  input  logic                      i_imem_req_ready,
  output logic [XLEN-1:0]           o_imem_req_addr,
  input  logic                      i_imem_rsp_valid,
  input  logic [INSTR_W-1:0]        i_imem_rsp_data,
  output logic                      o_id_valid,
  input  logic                      i_id_ready,
  output logic [INSTR_W-1:0]        o_id_instr,
  output logic [XLEN-1:0]           o_id_pc,
  output logic [XLEN-1:0]           o_id_pc_plus4,
  output logic [$clog2(FQ_DEPTH):0] o_fq_count
);

  localparam int unsigned     CNT_W      = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned     SUM_W      = CNT_W + 1;
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rsp_pc;
  logic [XLEN-1:0]  redirect_tgt;
  logic [XLEN-1:0]  head_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] stale;
  logic [CNT_W-1:0] fq_count;
  logic             credit_ok;
  logic             req_fire;
  logic             rsp_ok;
  logic             enq;
  logic             deq;
  fq_entry_t        enq_entry;
  fq_entry_t        head_entry;

  assign redirect_tgt = i_redirect_pc & ALIGN_MASK;

  // Queued plus in-flight fetches never exceed the queue size, so enqueue never meets a full queue.
  assign credit_ok        = (SUM_W'(fq_count) + SUM_W'(outstanding)) < SUM_W'(FQ_DEPTH);
  assign o_imem_req_valid = !i_redirect && credit_ok;
  assign o_imem_req_addr  = pc;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = i_imem_rsp_valid && (outstanding != '0);
  assign enq    = rsp_ok && (stale == '0) && !i_redirect;

  assign o_id_valid = (fq_count != '0);
  assign deq        = o_id_valid && i_id_ready && !i_redirect;
  assign o_fq_count = fq_count;

  assign enq_entry = '{instr: i_imem_rsp_data, pc: PC_W'(rsp_pc)};

  if_sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flush   (i_redirect),
    .i_wr_en   (enq),
    .i_wr_data (enq_entry),
    .i_rd_en   (deq),
    .o_rd_data (head_entry),
    .o_count   (fq_count)
  );

  // Head is zeroed while the queue is empty so decode never sees uninitialised storage.
  assign head_pc       = XLEN'(head_entry.pc);
  assign o_id_instr    = o_id_valid ? head_entry.instr : '0;
  assign o_id_pc       = o_id_valid ? head_pc : '0;
  assign o_id_pc_plus4 = o_id_valid ? (head_pc + PC_INC) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= RESET_PC_A;
      rsp_pc      <= RESET_PC_A;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      if (req_fire && !rsp_ok) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (!req_fire && rsp_ok) begin
        outstanding <= outstanding - CNT_W'(1);
      end

      // Everything still in flight at a redirect belongs to the old path and is dropped on return.
      if (i_redirect) begin
        pc     <= redirect_tgt;
        rsp_pc <= redirect_tgt;
        stale  <= outstanding - CNT_W'(rsp_ok);
      end else begin
        if (req_fire) pc <= pc + PC_INC;
        if (rsp_ok) begin
          if (stale != '0) begin
            stale <= stale - CNT_W'(1);
          end else begin
            rsp_pc <= rsp_pc + PC_INC;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: two instances (default, and high reset PC with a deeper
// queue) behind one in-order memory model; the idle instance is held in reset.
module tb_if_prefetch;

  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, redirect, req_ready, rsp_valid, id_ready, sel;
  logic [31:0] redirect_pc, rsp_data;
  logic        req_valid0, req_valid1, id_valid0, id_valid1;
  logic [31:0] req_addr0, req_addr1, id_instr0, id_instr1;
  logic [31:0] id_pc0, id_pc1, id_pc4_0, id_pc4_1;
  logic [2:0]  fq_count0;
  logic [3:0]  fq_count1;

  logic        req_valid, id_valid;
  logic [31:0] req_addr, id_instr, id_pc, id_pc4;
  logic [3:0]  fq_count;

  if_prefetch #(.XLEN(32), .FQ_DEPTH(4), .RESET_PC(32'h0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req_valid(req_valid0), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr0),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .o_id_valid(id_valid0), .i_id_ready(id_ready), .o_id_instr(id_instr0),
    .o_id_pc(id_pc0), .o_id_pc_plus4(id_pc4_0), .o_fq_count(fq_count0)
  );

  if_prefetch #(.XLEN(32), .FQ_DEPTH(8), .RESET_PC(RPC1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req_valid(req_valid1), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr1),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .o_id_valid(id_valid1), .i_id_ready(id_ready), .o_id_instr(id_instr1),
    .o_id_pc(id_pc1), .o_id_pc_plus4(id_pc4_1), .o_fq_count(fq_count1)
  );

  assign req_valid = sel ? req_valid1 : req_valid0;
  assign req_addr  = sel ? req_addr1  : req_addr0;
  assign id_valid  = sel ? id_valid1  : id_valid0;
  assign id_instr  = sel ? id_instr1  : id_instr0;
  assign id_pc     = sel ? id_pc1     : id_pc0;
  assign id_pc4    = sel ? id_pc4_1   : id_pc4_0;
  assign fq_count  = sel ? fq_count1  : {1'b0, fq_count0};

  mreq_t       mem_q[$];
  ent_t        sb[$];
  int          cyc, lat, model_out, proto_err, n_tests, n_fail;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic cur_rst();
    return sel ? rst1 : rst0;
  endfunction

  function automatic int cur_depth();
    return sel ? 8 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: present the memory response, check outputs, advance the model, cross the edge.
  task automatic step();
    mreq_t m;
    ent_t  e;
    logic  fire;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mem_q[0].addr);
    end
    #1;
    if (cur_rst()) begin
      if (rsp_valid) m = mem_q.pop_front();
      for (int i = 0; i < mem_q.size(); i++) mem_q[i].stale = 1'b1;
      sb.delete();
      model_out = 0;
      exp_pc    = sel ? RPC1 : 32'h0;
    end else begin
      check("req_valid", 32'(req_valid),
            32'(!redirect && ((sb.size() + model_out) < cur_depth())));
      check("fq_count", 32'(fq_count), 32'(sb.size()));
      check("id_valid", 32'(id_valid), 32'(sb.size() != 0));
      if (id_valid && sb.size() != 0) begin
        check("id_pc", id_pc, sb[0].pc);
        check("id_pc_plus4", id_pc4, sb[0].pc + 32'd4);
        check("id_instr", id_instr, sb[0].instr);
      end
      if (id_valid && id_ready && !redirect && sb.size() != 0) e = sb.pop_front();
      if (rsp_valid) begin
        m = mem_q.pop_front();
        if (model_out == 0) begin
          proto_err++;
        end else begin
          model_out--;
          if (!m.stale && !redirect) sb.push_back('{instr: mem_word(m.addr), pc: m.addr});
        end
      end
      fire = req_valid && req_ready;
      if (fire) begin
        check("req_addr", req_addr, exp_pc);
        mem_q.push_back('{addr: exp_pc, due: cyc + lat, stale: 1'b0});
        exp_pc = exp_pc + 32'd4;
        model_out++;
      end
      if (redirect) begin
        for (int i = 0; i < mem_q.size(); i++) mem_q[i].stale = 1'b1;
        sb.delete();
        exp_pc = redirect_pc & ~32'h3;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget    = 0;
    req_ready = 1'b0;
    redirect  = 1'b0;
    while (mem_q.size() != 0 && budget < 20) begin
      step();
      budget++;
    end
    check("drain_timeout", 32'(mem_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    drain();
    if (sel) rst1 = 1'b1; else rst0 = 1'b1;
    step();
    step();
    if (sel) rst1 = 1'b0; else rst0 = 1'b0;
  endtask

  task automatic wait_id();
    int budget;
    budget = 0;
    while (!id_valid && budget < 20) begin
      step();
      budget++;
    end
    check("wait_id_timeout", 32'(id_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat = 1; model_out = 0; proto_err = 0; exp_pc = '0;
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; redirect = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; id_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    @(negedge clk);
    step();
    step();

    check("rst_req_valid", 32'(req_valid), 32'd1);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc_plus4", id_pc4, 32'h0);
    rst0 = 1'b0;

    // Latency 1, decode always ready: streaming fetch.
    step();
    step();
    check("t1_pc0", id_pc, 32'h0);
    check("t1_pc4_0", id_pc4, 32'h4);
    step();
    check("t1_pc1", id_pc, 32'h4);
    check("t1_pc4_1", id_pc4, 32'h8);
    step();
    check("t1_pc2", id_pc, 32'h8);
    check("t1_pc4_2", id_pc4, 32'hC);
    repeat (8) step();

    // Decode stalled: credits stop requests once the queue fills.
    do_reset();
    req_ready = 1'b1;
    id_ready  = 1'b0;
    repeat (6) step();
    check("t2_count", 32'(fq_count), 32'd4);
    check("t2_req_valid", 32'(req_valid), 32'd0);
    check("t2_hold_pc", id_pc, 32'h0);
    repeat (3) step();
    check("t2_still_hold", id_pc, 32'h0);
    id_ready = 1'b1;
    step();
    check("t2_next_pc", id_pc, 32'h4);
    repeat (8) step();

    // Latency 3, redirect with two fetches in flight; low target bits are masked.
    do_reset();
    lat = 3; req_ready = 1'b1; id_ready = 1'b1;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    check("t3_count", 32'(fq_count), 32'd0);
    check("t3_req_addr", req_addr, 32'h100);
    wait_id();
    check("t3_first_pc", id_pc, 32'h100);
    check("t3_first_instr", id_instr, mem_word(32'h100));
    repeat (6) step();

    // Redirect coincides with the only outstanding response.
    do_reset();
    lat = 1; req_ready = 1'b1; id_ready = 1'b1;
    step();
    req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h202;
    step();
    redirect = 1'b0; req_ready = 1'b1;
    check("t4_count", 32'(fq_count), 32'd0);
    check("t4_req_addr", req_addr, 32'h200);
    wait_id();
    check("t4_first_pc", id_pc, 32'h200);
    check("t4_first_instr", id_instr, mem_word(32'h200));
    repeat (6) step();

    // Second instance: PC wraps past the top of the address space.
    drain();
    rst0 = 1'b1;
    sel  = 1'b1;
    do_reset();
    lat = 1; req_ready = 1'b1; id_ready = 1'b1;
    check("t5_addr0", req_addr, 32'hFFFF_FFF8);
    step();
    check("t5_addr1", req_addr, 32'hFFFF_FFFC);
    step();
    check("t5_addr2", req_addr, 32'h0);
    check("t5_id_pc0", id_pc, 32'hFFFF_FFF8);
    step();
    check("t5_id_pc1", id_pc, 32'hFFFF_FFFC);
    check("t5_id_pc4_1", id_pc4, 32'h0);
    repeat (6) step();

    // Reset mid-flight with three outstanding and two queued; late responses must be ignored.
    do_reset();
    lat = 3; req_ready = 1'b1; id_ready = 1'b0;
    repeat (5) step();
    check("t6_pre_count", 32'(fq_count), 32'd2);
    req_ready = 1'b0;
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    check("t6_id_valid", 32'(id_valid), 32'd0);
    check("t6_count", 32'(fq_count), 32'd0);
    check("t6_req_addr", req_addr, RPC1);
    repeat (3) step();
    check("t6_late_count", 32'(fq_count), 32'd0);
    check("t6_late_id_valid", 32'(id_valid), 32'd0);
    $display("[TB] late responses after reset: %0d", proto_err);
    req_ready = 1'b1; id_ready = 1'b1;
    wait_id();
    check("t6_first_pc", id_pc, RPC1);

    // Random handshakes and occasional redirects.
    lat = 2;
    for (int i = 0; i < 300; i++) begin
      req_ready   = ($urandom_range(0, 3) != 0);
      id_ready    = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom();
      step();
    end
    redirect = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
